// File: rtl/sobel_gradient_gen_pkg.sv
// Shared widths, pixel/gradient types and the magnitude helper for the Sobel gradient front end.
package sobel_gradient_gen_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned GRAD_W = 8;
    localparam int unsigned SUM_W  = 11;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic [GRAD_W-1:0]        grad_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    function automatic sum_t widen(pixel_t p);
        return sum_t'({{(SUM_W-PIX_W){1'b0}}, p});
    endfunction

    // Kernel sums stay within +-1020, so negation never overflows SUM_W.
    function automatic grad_t abs_sat(sum_t s);
        sum_t mag;
        mag = s[SUM_W-1] ? -s : s;
        if (mag > sum_t'(255)) begin
            return '1;
        end
        return mag[GRAD_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_gradient_gen_if.sv
// Pixel-in / gradient-out bundle; master is the pixel source, slave is the Sobel block.
interface sobel_gradient_gen_if;
    import sobel_gradient_gen_pkg::*;

    logic   frame_start;
    logic   pixel_valid;
    pixel_t pixel;
    grad_t  gx;
    grad_t  gy;
    logic   grad_valid;
    logic   frame_done;

    modport master (
        output frame_start, pixel_valid, pixel,
        input  gx, gy, grad_valid, frame_done
    );

    modport slave (
        input  frame_start, pixel_valid, pixel,
        output gx, gy, grad_valid, frame_done
    );

endinterface

// File: rtl/sobel_gradient_gen_line_buffer.sv
// One image row of pixel storage; read and write share an index and the read returns pre-write data.
module sobel_gradient_gen_line_buffer
    import sobel_gradient_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sobel_gradient_gen.sv
// Streaming 3x3 Sobel front end producing saturated |Gx|/|Gy| one clock after each qualifying pixel.
// Define SOBEL_BORDER_EN to emit a (zero-forced) result for every accepted pixel, borders included.
module sobel_gradient_gen
    import sobel_gradient_gen_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16
) (
    input logic                 clk,
    input logic                 rst,
    sobel_gradient_gen_if.slave bus
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          accept, col_wrap, interior, last_pix;

    pixel_t lb0_rd, lb1_rd;
    pixel_t [2:0][2:0] win_q, win_d;
    sum_t   gx_sum, gy_sum;

    grad_t  gx_q, gx_d, gy_q, gy_d;
    logic   grad_valid_q, grad_valid_d;
    logic   frame_done_q, frame_done_d;

    // frame_start re-origins the pixel presented in the same cycle.
    assign col_cur  = bus.frame_start ? '0 : col_q;
    assign row_cur  = bus.frame_start ? '0 : row_q;
    assign accept   = bus.pixel_valid;
    assign col_wrap = (col_cur == COL_LAST);
    assign last_pix = col_wrap && (row_cur == ROW_LAST);
    assign interior = (row_cur >= RW'(2)) && (col_cur >= CW'(2));

    always_comb begin
        col_d = col_cur;
        row_d = row_cur;
        if (accept) begin
            col_d = col_wrap ? '0 : col_cur + CW'(1);
            if (col_wrap) begin
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end
        end
    end

    sobel_gradient_gen_line_buffer #(
        .DEPTH (IMG_WIDTH)
    ) u_lb0 (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .addr  (col_cur),
        .wdata (bus.pixel),
        .rdata (lb0_rd)
    );

    sobel_gradient_gen_line_buffer #(
        .DEPTH (IMG_WIDTH)
    ) u_lb1 (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .addr  (col_cur),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Row 0 of the window is the oldest line, column 2 the newest pixel.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = bus.pixel;
        end
    end

    always_comb begin
        gx_sum = (widen(win_d[0][2]) + widen(win_d[1][2]) + widen(win_d[1][2])
                  + widen(win_d[2][2]))
               - (widen(win_d[0][0]) + widen(win_d[1][0]) + widen(win_d[1][0])
                  + widen(win_d[2][0]));
        gy_sum = (widen(win_d[2][0]) + widen(win_d[2][1]) + widen(win_d[2][1])
                  + widen(win_d[2][2]))
               - (widen(win_d[0][0]) + widen(win_d[0][1]) + widen(win_d[0][1])
                  + widen(win_d[0][2]));
    end

    always_comb begin
        gx_d         = gx_q;
        gy_d         = gy_q;
        grad_valid_d = 1'b0;
        frame_done_d = 1'b0;
        if (accept) begin
            frame_done_d = last_pix;
`ifdef SOBEL_BORDER_EN
            grad_valid_d = 1'b1;
            gx_d         = interior ? abs_sat(gx_sum) : '0;
            gy_d         = interior ? abs_sat(gy_sum) : '0;
`else
            grad_valid_d = interior;
            if (interior) begin
                gx_d = abs_sat(gx_sum);
                gy_d = abs_sat(gy_sum);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            grad_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            grad_valid_q <= grad_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.gx         = gx_q;
    assign bus.gy         = gy_q;
    assign bus.grad_valid = grad_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule
